sensor_model_ctrl: RTL
======================

// Module: sensor_model_ctrl
// PURPOSE
//  Run/stop sequencer and timing-register bank for the sensor simulation model.
//  The host writes geometry registers into shadow copies. Shadow values reach the model
//  only at frame boundaries, so no frame is produced with mixed geometry.
//  The block drives the model's pause/continue_lval controls and runs N frames or free-runs.
//  It sits between the testbench host task and the model's iv_* / i_pause_en inputs.
// PARAMETERS
//  DEF_WIDTH       16'd64  reset value of width register
//  DEF_LINE_HIDE   16'd16  reset value of line_hide register
//  DEF_HEIGHT      16'd32  reset value of height register
//  DEF_FRAME_HIDE  16'd64  reset value of frame_hide register
//  DEF_FRONT_PORCH 16'd4   reset value of front_porch register
//  DEF_BACK_PORCH  16'd4   reset value of back_porch register
// PORTS
//  clk             in   1   model clock
//  reset_n         in   1   asynchronous reset, active low
//  i_wr_en         in   1   register write strobe, 1 cycle per write
//  iv_wr_addr      in   3   0 width,1 line_hide,2 height,3 frame_hide,4 front_porch,5 back_porch,6 ctrl,7 ignored
//  iv_wr_data      in   16  write data; ctrl bit0 = continue_lval
//  i_start         in   1   start pulse
//  i_stop          in   1   stop pulse
//  iv_frame_num    in   16  frames per run, sampled on start; 0 = free-run
//  i_fval          in   1   frame valid returned from the model
//  ov_width..ov_back_porch out 16 each  committed timing to model iv_* (6 ports)
//  o_continue_lval out  1   committed ctrl bit0
//  o_pause_en      out  1   to model i_pause_en
//  o_busy          out  1   state != IDLE
//  o_done          out  1   1-cycle pulse when a run or stop completes
//  ov_frame_cnt    out  16  frames completed in the current run
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Shadow and committed registers load DEF_*; continue_lval = 0.
//   - State = IDLE; o_pause_en = 1; o_busy = 0; o_done = 0; ov_frame_cnt = 0; fval_d = 0.
//  Writes
//   - i_wr_en writes shadow[iv_wr_addr] at the clock edge. Address 7 is a no-op.
//  Frame-end detection
//   - fval_fall = fval_d & ~i_fval, where fval_d is i_fval registered.
//  Commit (all 7 registers copied shadow -> committed in one edge)
//   - Occurs when fval_fall = 1, or when state == IDLE and i_fval == 0.
//   - Commit uses shadow values from before the same-cycle write. That write commits at the next commit point.
//   - Committed outputs never change while i_fval = 1 in RUN or STOPPING.
//  FSM
//   - IDLE: o_pause_en = 1.
//     - i_start & ~i_stop: latch target = iv_frame_num, clear frame_cnt, go to RUN.
//   - RUN: o_pause_en = 0.
//     - fval_fall: frame_cnt += 1 (16-bit, wraps in free-run).
//     - If target != 0 and frame_cnt+1 == target: go to IDLE, pulse o_done.
//     - i_stop with i_fval == 0: go to IDLE next edge, pulse o_done.
//     - i_stop with i_fval == 1: go to STOPPING.
//   - STOPPING: o_pause_en = 0.
//     - On fval_fall: frame_cnt += 1, go to IDLE, pulse o_done.
//  Simultaneous events
//   - i_stop has priority over i_start.
//   - i_start outside IDLE is ignored.
//   - fval_fall together with i_stop in RUN counts the frame, then goes to IDLE.
//  Pause latency
//   - o_pause_en rises 1 cycle after fval falls; it is registered.
//   - Model frame_hide must be >= 2 so no new frame starts before pause.
//  Mid-run reset
//   - Immediate IDLE with pause = 1 and DEF_* outputs.
//   - The model may output a truncated frame; the bench tolerates it.
// TESTING
//  - Reset: hold reset_n = 0 -> o_pause_en = 1, ov_width = 64, o_busy = 0, ov_frame_cnt = 0.
//  - Start with iv_frame_num = 3 -> exactly 3 fval pulses, o_done 1 cycle after the 3rd fall, pause = 1, frame_cnt = 3.
//  - Write width = 128 mid-frame 1 of a free-run -> frame 1 lval length 64, frame 2 length 128;
//    ov_width changes on the cycle after the fval fall.
//  - i_stop during fval high in free-run -> STOPPING, frame completes, pause and o_done 1 cycle after the fall.
//  - i_stop and i_start in the same cycle while IDLE -> remains IDLE, no o_done.
//  - Write addr 7 = 0xFFFF, then commit -> all outputs unchanged.
//  - reset_n low mid-frame -> outputs return to defaults asynchronously; a later start runs cleanly.

Source files
------------

// File: rtl/sensor_model_ctrl.sv
// Run/stop sequencer and timing-register bank for the sensor simulation model.
// Host writes land in shadow registers and are committed to the model only at frame boundaries.
module sensor_model_ctrl #(
  parameter logic [15:0] DEF_WIDTH       = 16'd64,
  parameter logic [15:0] DEF_LINE_HIDE   = 16'd16,
  parameter logic [15:0] DEF_HEIGHT      = 16'd32,
  parameter logic [15:0] DEF_FRAME_HIDE  = 16'd64,
  parameter logic [15:0] DEF_FRONT_PORCH = 16'd4,
  parameter logic [15:0] DEF_BACK_PORCH  = 16'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wr_en,
  input  logic [2:0]  iv_wr_addr,
  input  logic [15:0] iv_wr_data,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [15:0] iv_frame_num,
  input  logic        i_fval,
  output logic [15:0] ov_width,
  output logic [15:0] ov_line_hide,
  output logic [15:0] ov_height,
  output logic [15:0] ov_frame_hide,
  output logic [15:0] ov_front_porch,
  output logic [15:0] ov_back_porch,
  output logic        o_continue_lval,
  output logic        o_pause_en,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] ov_frame_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  state_e      state_q;
  logic [15:0] target_q;
  logic [15:0] frame_cnt_q;
  logic        pause_q;
  logic        busy_q;
  logic        done_q;
  logic        fval_q;

  logic [15:0] sh_width_q, sh_line_hide_q, sh_height_q;
  logic [15:0] sh_frame_hide_q, sh_front_porch_q, sh_back_porch_q;
  logic        sh_cont_q;
  logic [15:0] sh_width_d, sh_line_hide_d, sh_height_d;
  logic [15:0] sh_frame_hide_d, sh_front_porch_d, sh_back_porch_d;
  logic        sh_cont_d;

  logic [15:0] cm_width_q, cm_line_hide_q, cm_height_q;
  logic [15:0] cm_frame_hide_q, cm_front_porch_q, cm_back_porch_q;
  logic        cm_cont_q;
  logic [15:0] cm_width_d, cm_line_hide_d, cm_height_d;
  logic [15:0] cm_frame_hide_d, cm_front_porch_d, cm_back_porch_d;
  logic        cm_cont_d;

  logic        fval_fall;
  logic        commit;
  logic [15:0] frame_cnt_inc;

  assign fval_fall     = fval_q & ~i_fval;
  // Idle with no frame in flight is also a safe boundary, so idle writes take effect promptly.
  assign commit        = fval_fall | ((state_q == StIdle) & ~i_fval);
  assign frame_cnt_inc = frame_cnt_q + 16'd1;

  always_comb begin
    sh_width_d       = sh_width_q;
    sh_line_hide_d   = sh_line_hide_q;
    sh_height_d      = sh_height_q;
    sh_frame_hide_d  = sh_frame_hide_q;
    sh_front_porch_d = sh_front_porch_q;
    sh_back_porch_d  = sh_back_porch_q;
    sh_cont_d        = sh_cont_q;
    if (i_wr_en) begin
      case (iv_wr_addr)
        3'd0:    sh_width_d       = iv_wr_data;
        3'd1:    sh_line_hide_d   = iv_wr_data;
        3'd2:    sh_height_d      = iv_wr_data;
        3'd3:    sh_frame_hide_d  = iv_wr_data;
        3'd4:    sh_front_porch_d = iv_wr_data;
        3'd5:    sh_back_porch_d  = iv_wr_data;
        3'd6:    sh_cont_d        = iv_wr_data[0];
        default: ;
      endcase
    end
  end

  // Commit copies the pre-write shadow; a same-cycle write waits for the next boundary.
  always_comb begin
    cm_width_d       = cm_width_q;
    cm_line_hide_d   = cm_line_hide_q;
    cm_height_d      = cm_height_q;
    cm_frame_hide_d  = cm_frame_hide_q;
    cm_front_porch_d = cm_front_porch_q;
    cm_back_porch_d  = cm_back_porch_q;
    cm_cont_d        = cm_cont_q;
    if (commit) begin
      cm_width_d       = sh_width_q;
      cm_line_hide_d   = sh_line_hide_q;
      cm_height_d      = sh_height_q;
      cm_frame_hide_d  = sh_frame_hide_q;
      cm_front_porch_d = sh_front_porch_q;
      cm_back_porch_d  = sh_back_porch_q;
      cm_cont_d        = sh_cont_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fval_q           <= 1'b0;
      sh_width_q       <= DEF_WIDTH;
      sh_line_hide_q   <= DEF_LINE_HIDE;
      sh_height_q      <= DEF_HEIGHT;
      sh_frame_hide_q  <= DEF_FRAME_HIDE;
      sh_front_porch_q <= DEF_FRONT_PORCH;
      sh_back_porch_q  <= DEF_BACK_PORCH;
      sh_cont_q        <= 1'b0;
      cm_width_q       <= DEF_WIDTH;
      cm_line_hide_q   <= DEF_LINE_HIDE;
      cm_height_q      <= DEF_HEIGHT;
      cm_frame_hide_q  <= DEF_FRAME_HIDE;
      cm_front_porch_q <= DEF_FRONT_PORCH;
      cm_back_porch_q  <= DEF_BACK_PORCH;
      cm_cont_q        <= 1'b0;
    end else begin
      fval_q           <= i_fval;
      sh_width_q       <= sh_width_d;
      sh_line_hide_q   <= sh_line_hide_d;
      sh_height_q      <= sh_height_d;
      sh_frame_hide_q  <= sh_frame_hide_d;
      sh_front_porch_q <= sh_front_porch_d;
      sh_back_porch_q  <= sh_back_porch_d;
      sh_cont_q        <= sh_cont_d;
      cm_width_q       <= cm_width_d;
      cm_line_hide_q   <= cm_line_hide_d;
      cm_height_q      <= cm_height_d;
      cm_frame_hide_q  <= cm_frame_hide_d;
      cm_front_porch_q <= cm_front_porch_d;
      cm_back_porch_q  <= cm_back_porch_d;
      cm_cont_q        <= cm_cont_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      target_q    <= 16'd0;
      frame_cnt_q <= 16'd0;
      pause_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Stop wins over a simultaneous start.
          if (i_start && !i_stop) begin
            state_q     <= StRun;
            target_q    <= iv_frame_num;
            frame_cnt_q <= 16'd0;
            pause_q     <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StRun: begin
          if (fval_fall) frame_cnt_q <= frame_cnt_inc;
          if ((fval_fall && (target_q != 16'd0) && (frame_cnt_inc == target_q)) ||
              (i_stop && !i_fval)) begin
            state_q <= StIdle;
            pause_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (i_stop) begin
            state_q <= StStopping;
          end
        end
        StStopping: begin
          if (fval_fall) begin
            frame_cnt_q <= frame_cnt_inc;
            state_q     <= StIdle;
            pause_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          pause_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ov_width        = cm_width_q;
  assign ov_line_hide    = cm_line_hide_q;
  assign ov_height       = cm_height_q;
  assign ov_frame_hide   = cm_frame_hide_q;
  assign ov_front_porch  = cm_front_porch_q;
  assign ov_back_porch   = cm_back_porch_q;
  assign o_continue_lval = cm_cont_q;
  assign o_pause_en      = pause_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign ov_frame_cnt    = frame_cnt_q;

endmodule
